tx_fsm: RTL and testbench
=========================

# tx_fsm

USB UTMI transmit path: accepts bytes from the link layer over a valid/ready handshake and serialises them onto the dpt/dmt line pair. Each packet is sent as SYNC, then bit-stuffed and NRZI-encoded data, then EOP. It mirrors the receive chain (sync detect, NRZI decode, unstuff, hold/shift) and runs entirely on clk_480mhz, one line bit per clock.

## Interface
- W, 8, data byte width
- clk_480mhz  in  1  bit clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- tx_valid  in  1  link layer has a byte on tx_data / wants the packet to continue
- tx_data  in  W  byte to send, LSB first
- tx_ready  out  1  one-cycle strobe: tx_data is consumed this cycle when tx_valid=1
- tx_active  out  1  high while the block drives a packet (first SYNC K through EOP J)
- dpt  out  1  D+ line level, registered
- dmt  out  1  D- line level, registered

## Operation
- Line encodings: J = dpt 1 / dmt 0; K = dpt 0 / dmt 1; SE0 = 0/0. Idle line is J.
- States:
  - IDLE
  - SYNC: 8 bits
  - DATA
  - LAST_STUFF
  - EOP_SE0: 2 cycles
  - EOP_J: 1 cycle
- IDLE → SYNC when tx_valid=1. The shift register loads 8'h80; bit index is 0 and ones_cnt is 0.
- SYNC/DATA, one bit per cycle, LSB first:
  - If ones_cnt==6, emit a stuffed 0: toggle the line, set ones_cnt=0, shift register holds.
  - Otherwise emit the shift register LSB.
  - NRZI rule: a 0 toggles the J/K level; a 1 holds the level and increments ones_cnt. A 0 clears ones_cnt.
- The SYNC pattern yields KJKJKJKK. The final SYNC 1 counts toward stuffing.
- Load point: the last-bit cycle of a byte (bit index 7, non-stuff cycle). tx_ready=1 there, and only there.
  - If tx_valid=1: shift register ← tx_data, go to DATA, bit index 0.
  - If tx_valid=0 and the updated ones_cnt==6: go to LAST_STUFF.
  - If tx_valid=0 otherwise: go to EOP_SE0.
- tx_valid and tx_data are sampled only at IDLE and at load points. The source holds both until tx_ready.
- SYNC end with tx_valid=0 gives a zero-length packet: SYNC then EOP.
- LAST_STUFF: emit one stuffed 0, then EOP_SE0.
- EOP_SE0: 2 cycles of SE0, then EOP_J for 1 cycle, then IDLE. The NRZI level register resets to J.
- Reset values: state IDLE, dpt=1, dmt=0, tx_ready=0, tx_active=0, ones_cnt=0, NRZI level J.
- Reset mid-packet: the line shows J on the cycle after reset is sampled. No EOP is sent. The next packet starts with a full SYNC.

## Timing
- tx_valid sampled high in IDLE at edge E: first SYNC cycle follows E, and its K appears on dpt/dmt after edge E+1.
- Line outputs lag the state cycle that produced them by exactly 1 clock.
- tx_active is registered and aligned with the line outputs: high from the first K through the EOP J cycle, low on the following cycle.
- tx_ready is combinational from state, bit index and ones_cnt. It never asserts in a stuff cycle, IDLE, LAST_STUFF or EOP states.
- Byte period is 8 cycles, plus 1 per stuffed bit. Spacing between tx_ready strobes equals the byte period.
- At least 1 IDLE cycle separates packets, even with tx_valid held high.

## Structure
- Shared package usb_utmi_pkg holds:
  - state enum
  - LINE_J, LINE_K, LINE_SE0 constants
  - SYNC_BYTE = 8'h80
  - STUFF_LIMIT = 6
- Sub-module nrzi_enc (counterpart of nrzi_dec) contains the level register and J/K/SE0 output mapping. Its inputs are bit, bit-valid and force-SE0/force-J.
- Stuff counting and the FSM stay in tx_fsm.

## Test plan
- Reset → dpt=1, dmt=0, tx_ready=0, tx_active=0. They hold with tx_valid=0.
- Single byte 0x00 → line KJKJKJKK, JKJKJKJK, SE0, SE0, J.
  - tx_ready strobes twice: at SYNC end, where tx_data=0x00 is consumed, and at the byte end with tx_valid=0.
- Byte 0xFF → after SYNC: K×5, stuffed J, J×3, SE0, SE0, J. The byte spans 9 cycles.
- Byte 0xFC, last byte → after SYNC: J, K, K×6, LAST_STUFF J, SE0, SE0, J.
- Two bytes 0x55, 0xAA with tx_valid held → tx_ready strobes exactly 8 cycles apart. No stuffing occurs. The line matches the NRZI of the bit stream.
- rst asserted during byte 2 → J on the next cycle, tx_active=0. A new packet after reset begins with a full KJKJKJKK.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI definitions: transmit FSM states, line encodings and bit-stuffing constants.
package usb_utmi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_LAST_STUFF,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_t;

   // Line levels packed as {dpt, dmt}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [7:0] SYNC_BYTE   = 8'h80;
   localparam int         STUFF_LIMIT = 6;

endpackage

// File: rtl/nrzi_enc.sv
// NRZI encoder: holds the J/K level, toggles it on a 0 bit, and drives the registered
// line pair, with overrides for SE0 and for forcing J at end of packet.
module nrzi_enc
   import usb_utmi_pkg::*;
(
   input  logic clk_480mhz,
   input  logic rst,
   input  logic bit_in,
   input  logic bit_vld,
   input  logic force_se0,
   input  logic force_j,
   output logic dpt,
   output logic dmt
);

   logic lvl_k;
   logic lvl_nxt;

   // SE0 leaves the level untouched; the closing J returns it to idle.
   always_comb begin
      lvl_nxt = lvl_k;
      if (force_se0)
         lvl_nxt = lvl_k;
      else if (force_j)
         lvl_nxt = 1'b0;
      else if (bit_vld && !bit_in)
         lvl_nxt = ~lvl_k;
   end

   always_ff @(posedge clk_480mhz) begin
      if (rst) begin
         lvl_k      <= 1'b0;
         {dpt, dmt} <= LINE_J;
      end else begin
         lvl_k      <= lvl_nxt;
         {dpt, dmt} <= force_se0 ? LINE_SE0 : (lvl_nxt ? LINE_K : LINE_J);
      end
   end

endmodule

// File: rtl/tx_fsm.sv
// UTMI transmit path: SYNC, bit-stuffed LSB-first data and EOP, one line bit per clock,
// with a valid/ready byte handshake toward the link layer.
module tx_fsm
   import usb_utmi_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_480mhz,
   input  logic         rst,
   input  logic         tx_valid,
   input  logic [W-1:0] tx_data,
   output logic         tx_ready,
   output logic         tx_active,
   output logic         dpt,
   output logic         dmt
);

   localparam int BW = $clog2(W);

   tx_state_t     state;
   logic [W-1:0]  sr;
   logic [BW-1:0] bit_idx;
   logic [2:0]    ones_cnt;

   logic       in_bits;
   logic       stuff;
   logic       last_bit;
   logic       cur_bit;
   logic       bit_vld;
   logic [2:0] ones_nxt;

   always_comb begin
      in_bits  = (state == ST_SYNC) || (state == ST_DATA);
      stuff    = in_bits && (ones_cnt == 3'(STUFF_LIMIT));
      last_bit = bit_idx == BW'(W - 1);
      cur_bit  = (stuff || state == ST_LAST_STUFF) ? 1'b0 : sr[0];
      bit_vld  = in_bits || (state == ST_LAST_STUFF);
      ones_nxt = (stuff || !cur_bit) ? 3'd0 : ones_cnt + 3'd1;
      tx_ready = in_bits && !stuff && last_bit;
   end

   always_ff @(posedge clk_480mhz) begin
      if (rst) begin
         state     <= ST_IDLE;
         sr        <= '0;
         bit_idx   <= '0;
         ones_cnt  <= '0;
         tx_active <= 1'b0;
      end else begin
         tx_active <= (state != ST_IDLE);
         unique case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  state    <= ST_SYNC;
                  sr       <= W'(SYNC_BYTE);
                  bit_idx  <= '0;
                  ones_cnt <= '0;
               end
            end
            ST_SYNC, ST_DATA: begin
               ones_cnt <= ones_nxt;
               // A stuff cycle leaves the shift register and bit index where they are.
               if (!stuff) begin
                  if (last_bit) begin
                     bit_idx <= '0;
                     if (tx_valid) begin
                        sr    <= tx_data;
                        state <= ST_DATA;
                     end else if (ones_nxt == 3'(STUFF_LIMIT)) begin
                        state <= ST_LAST_STUFF;
                     end else begin
                        state <= ST_EOP_SE0;
                     end
                  end else begin
                     sr      <= sr >> 1;
                     bit_idx <= bit_idx + BW'(1);
                  end
               end
            end
            ST_LAST_STUFF: begin
               ones_cnt <= '0;
               bit_idx  <= '0;
               state    <= ST_EOP_SE0;
            end
            ST_EOP_SE0: begin
               // bit_idx doubles as the SE0 cycle counter
               if (bit_idx == BW'(1))
                  state <= ST_EOP_J;
               else
                  bit_idx <= bit_idx + BW'(1);
            end
            ST_EOP_J: begin
               bit_idx <= '0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   nrzi_enc u_nrzi_enc (
      .clk_480mhz (clk_480mhz),
      .rst        (rst),
      .bit_in     (cur_bit),
      .bit_vld    (bit_vld),
      .force_se0  (state == ST_EOP_SE0),
      .force_j    (state == ST_EOP_J),
      .dpt        (dpt),
      .dmt        (dmt)
   );

endmodule

// File: tb/tb_tx_fsm.sv
// Table-driven bench for tx_fsm: per-cycle vectors of inputs and expected line/handshake outputs.
module tb_tx_fsm;

   logic       clk_480mhz = 1'b0;
   logic       rst        = 1'b1;
   logic       tx_valid   = 1'b0;
   logic [7:0] tx_data    = 8'h00;
   logic       tx_ready;
   logic       tx_active;
   logic       dpt;
   logic       dmt;

   tx_fsm #(.W(8)) dut (
      .clk_480mhz (clk_480mhz),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_active  (tx_active),
      .dpt        (dpt),
      .dmt        (dmt)
   );

   always #5 clk_480mhz = ~clk_480mhz;

   typedef struct {
      string      tag;
      logic       rst;
      logic       vld;
      logic [7:0] data;
      logic       chk;
      byte        ln;
      logic       rdy;
      logic       act;
   } vec_t;

   vec_t vq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [1:0] line_of(byte c);
      if (c == "J") return 2'b10;
      if (c == "K") return 2'b01;
      return 2'b00;
   endfunction

   task automatic push(string tag, logic r, logic v, logic [7:0] d, logic c, byte ln,
                       logic rdy, logic act);
      vec_t x;
      x.tag = tag; x.rst = r; x.vld = v; x.data = d; x.chk = c;
      x.ln = ln; x.rdy = rdy; x.act = act;
      vq.push_back(x);
   endtask

   // em: symbol emitted by each state cycle after the launch cycle; rdy/vld: per state
   // cycle. The line shows each symbol one cycle late. cut>=0 asserts rst at that state cycle.
   task automatic add_pkt(string tag, string em, string rdy, string vld,
                          logic [7:0] b0, logic [7:0] b1, int cut);
      logic [7:0] cur = b0;
      int n = (cut >= 0) ? cut : em.len();
      push(tag, 1'b0, 1'b1, b0, 1'b1, "J", 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         push(tag, 1'b0, vld[i] == "1", cur, 1'b1, (i == 0) ? byte'("J") : em[i-1],
              rdy[i] == "1", i >= 1);
         if (rdy[i] == "1" && vld[i] == "1") cur = b1;
      end
      if (cut >= 0) begin
         push({tag, "_rst"}, 1'b1, 1'b0, cur, 1'b1, em[cut-1], rdy[cut] == "1", 1'b1);
         push({tag, "_post"}, 1'b0, 1'b0, 8'h00, 1'b1, "J", 1'b0, 1'b0);
      end else begin
         push(tag, 1'b0, 1'b0, 8'h00, 1'b1, em[em.len()-1], 1'b0, 1'b1);
         push(tag, 1'b0, 1'b0, 8'h00, 1'b1, "J", 1'b0, 1'b0);
      end
   endtask

   task automatic check(string nm, int idx, logic [1:0] got, logic [1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s[%0d] got %b want %b", nm, idx, got, exp);
   endtask

   localparam string SYNC = "KJKJKJKK";

   initial begin
      // Reset, then idle with tx_valid low
      push("reset", 1'b1, 1'b0, 8'h00, 1'b0, "J", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push("reset_idle", 1'b0, 1'b0, 8'h00, 1'b1, "J", 1'b0, 1'b0);

      add_pkt("b00", {SYNC, "JKJKJKJK", "00J"},
              {"00000001", "00000001", "000"},
              {"11111111", "00000000", "000"}, 8'h00, 8'h00, -1);

      // Five ones then a stuffed J; the byte takes 9 cycles
      add_pkt("bFF", {SYNC, "KKKKKJJJJ", "00J"},
              {"00000001", "000000001", "000"},
              {"11111111", "000000000", "000"}, 8'hFF, 8'h00, -1);

      // Six ones end on the last bit, so a lone stuff bit precedes EOP
      add_pkt("bFC", {SYNC, "JKKKKKKK", "J", "00J"},
              {"00000001", "00000001", "0", "000"},
              {"11111111", "00000000", "0", "000"}, 8'hFC, 8'h00, -1);

      add_pkt("b55AA", {SYNC, "KJJKKJJK", "JJKKJJKK", "00J"},
              {"00000001", "00000001", "00000001", "000"},
              {"11111111", "11111111", "00000000", "000"}, 8'h55, 8'hAA, -1);

      // Reset during the second byte, then a fresh packet must start with full SYNC
      add_pkt("rst_mid", {SYNC, "KJJKKJJK", "JJKKJJKK", "00J"},
              {"00000001", "00000001", "00000001", "000"},
              {"11111111", "11111111", "00000000", "000"}, 8'h55, 8'hAA, 19);
      push("after_rst", 1'b0, 1'b0, 8'h00, 1'b1, "J", 1'b0, 1'b0);
      add_pkt("b00_again", {SYNC, "JKJKJKJK", "00J"},
              {"00000001", "00000001", "000"},
              {"11111111", "00000000", "000"}, 8'h00, 8'h00, -1);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk_480mhz);
         #1;
         rst      = vq[i].rst;
         tx_valid = vq[i].vld;
         tx_data  = vq[i].data;
         #3;
         if (vq[i].chk) begin
            check({vq[i].tag, "_line"}, i, {dpt, dmt}, line_of(vq[i].ln));
            check({vq[i].tag, "_ready"}, i, {1'b0, tx_ready}, {1'b0, vq[i].rdy});
            check({vq[i].tag, "_active"}, i, {1'b0, tx_active}, {1'b0, vq[i].act});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
